// File: rtl/bram_acc_engine.sv
// Streams N packed rows out of BRAM0, accumulates each lane, and writes running or
// final lane sums to BRAM1. Define ACC_SAT_EN to make the lanes saturate instead of wrap.
module bram_acc_engine #(
   parameter int NUM_LANES     = 4,
   parameter int IN_DATA_WIDTH = 8,
   parameter int ACC_WIDTH     = 16,
   parameter int AWIDTH        = 8,
   parameter int CNT_BIT       = 31
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start_run_i,
   input  logic [CNT_BIT-1:0]                 run_count_i,
   input  logic                               mode_i,
   input  logic [NUM_LANES*IN_DATA_WIDTH-1:0] q_b0_i,
   output logic [AWIDTH-1:0]                  addr_b0_o,
   output logic                               ce_b0_o,
   output logic                               we_b0_o,
   output logic [NUM_LANES*IN_DATA_WIDTH-1:0] d_b0_o,
   output logic [AWIDTH-1:0]                  addr_b1_o,
   output logic                               ce_b1_o,
   output logic                               we_b1_o,
   output logic [NUM_LANES*ACC_WIDTH-1:0]     d_b1_o,
   output logic                               idle_o,
   output logic                               read_o,
   output logic                               write_o,
   output logic                               done_o
);
   localparam int CW = AWIDTH + 1;
   localparam logic [CNT_BIT-1:0] MAX_CNT = CNT_BIT'(2 ** AWIDTH);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   state_t                               state_q, state_d;
   logic [CW-1:0]                        cnt_q, cnt_d;
   logic [CW-1:0]                        rd_q, rd_d;
   logic                                 mode_q, mode_d;
   // stage 1: BRAM0 data valid this cycle; stage 2: matching BRAM1 write slot
   logic [2:1]                           vld_pipe_q, vld_pipe_d;
   logic [2:1]                           last_pipe_q, last_pipe_d;
   logic [AWIDTH-1:0]                    a1_q, a1_d, a2_q, a2_d;
   logic [NUM_LANES-1:0][ACC_WIDTH-1:0]  acc_q, acc_d;

   logic [CW-1:0]                        cnt_in;
   logic                                 rd_last;
   logic [ACC_WIDTH:0]                   sum;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      mode_d      = mode_q;
      acc_d       = acc_q;
      sum         = '0;
      cnt_in      = (run_count_i > MAX_CNT) ? CW'(MAX_CNT) : CW'(run_count_i);
      rd_last     = (state_q == READ) && (rd_q == cnt_q - CW'(1));
      vld_pipe_d  = {vld_pipe_q[1], state_q == READ};
      last_pipe_d = {last_pipe_q[1], rd_last};
      a1_d        = rd_q[AWIDTH-1:0];
      a2_d        = a1_q;

      case (state_q)
         IDLE: if (start_run_i) begin
            cnt_d   = cnt_in;
            mode_d  = mode_i;
            rd_d    = '0;
            acc_d   = '0;
            state_d = (cnt_in == '0) ? DONE : READ;
         end
         READ: begin
            rd_d = rd_q + CW'(1);
            if (rd_last) state_d = DRAIN;
         end
         DRAIN: if (vld_pipe_q[2] && last_pipe_q[2]) state_d = DONE;
         default: state_d = IDLE;
      endcase

      if (vld_pipe_q[1]) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            sum = {1'b0, acc_q[i]} + (ACC_WIDTH+1)'(q_b0_i[i*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
`ifdef ACC_SAT_EN
            acc_d[i] = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
`else
            acc_d[i] = sum[ACC_WIDTH-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rd_q        <= '0;
         mode_q      <= 1'b0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         a1_q        <= '0;
         a2_q        <= '0;
         acc_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         mode_q      <= mode_d;
         vld_pipe_q  <= vld_pipe_d;
         last_pipe_q <= last_pipe_d;
         a1_q        <= a1_d;
         a2_q        <= a2_d;
         acc_q       <= acc_d;
      end
   end

   assign ce_b0_o   = (state_q == READ);
   assign addr_b0_o = ce_b0_o ? rd_q[AWIDTH-1:0] : '0;
   assign we_b0_o   = 1'b0;
   assign d_b0_o    = '0;
   // final-sum mode only writes on the slot carrying the last row
   assign ce_b1_o   = vld_pipe_q[2] && (!mode_q || last_pipe_q[2]);
   assign we_b1_o   = ce_b1_o;
   assign addr_b1_o = (ce_b1_o && !mode_q) ? a2_q : '0;
   assign d_b1_o    = ce_b1_o ? acc_q : '0;
   assign idle_o    = (state_q == IDLE);
   assign read_o    = ce_b0_o;
   assign write_o   = ce_b1_o;
   assign done_o    = (state_q == DONE);
endmodule

// File: doc/bram_acc_engine.md
BRAM_ACC_ENGINE -- requirements
Module: bram_acc_engine

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- NUM_LANES, 4, number of packed lanes per BRAM0 row
- IN_DATA_WIDTH, 8, width of one input lane
- ACC_WIDTH, 16, width of one accumulator lane
- AWIDTH, 8, address width of both BRAMs
- CNT_BIT, 31, width of run_count_i
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock, rising edge
- reset  in  1  async active-high reset
- start_run_i  in  1  start pulse
- run_count_i  in  CNT_BIT  rows to process
- mode_i  in  1  0 = write running sum per row, 1 = write final sum only
- q_b0_i  in  NUM_LANES*IN_DATA_WIDTH  BRAM0 read data
- addr_b0_o  out  AWIDTH  BRAM0 address
- ce_b0_o  out  1  BRAM0 chip enable
- we_b0_o  out  1  BRAM0 write enable, tied 0
- d_b0_o  out  NUM_LANES*IN_DATA_WIDTH  BRAM0 write data, tied 0
- addr_b1_o  out  AWIDTH  BRAM1 address
- ce_b1_o  out  1  BRAM1 chip enable
- we_b1_o  out  1  BRAM1 write enable
- d_b1_o  out  NUM_LANES*ACC_WIDTH  BRAM1 write data
- idle_o, read_o, write_o, done_o  out  1 each  status flags

Function
REQ-004 The FSM SHALL have states IDLE, READ, DRAIN, DONE; IDLE->READ on start_run_i with a nonzero count, READ->DRAIN after the last read is issued, DRAIN->DONE after the last BRAM1 write, DONE->IDLE after exactly 1 cycle.
REQ-005 On start in IDLE, the block SHALL latch run_count_i (clamped to 2^AWIDTH) and mode_i, and clear all accumulators.
REQ-006 start_run_i outside IDLE SHALL be ignored.
REQ-007 start_run_i with run_count_i==0 SHALL go IDLE->DONE->IDLE with no BRAM access.
REQ-008 In READ, ce_b0_o SHALL be 1 with addr_b0_o = 0,1,..,N-1, one row per cycle, with no gaps.
REQ-009 BRAM0 read latency SHALL be 1 cycle: q_b0_i for the address issued in cycle t is sampled at the end of cycle t+1.
REQ-010 Lane i of q_b0_i SHALL be bits [(i+1)*IN_DATA_WIDTH-1 : i*IN_DATA_WIDTH]; lane i of d_b1_o SHALL be bits [(i+1)*ACC_WIDTH-1 : i*ACC_WIDTH].
REQ-011 The accumulation SHALL be unsigned, acc[i] += zero-extended lane i, modulo 2^ACC_WIDTH, unless saturation is enabled (REQ-019).
REQ-012 In mode 0, for the row read at address k in cycle t, the block SHALL drive ce_b1_o=we_b1_o=1, addr_b1_o=k in cycle t+2, with d_b1_o = the sum of rows 0..k.
REQ-013 In mode 1, the block SHALL make exactly one BRAM1 write to address 0, 2 cycles after the last read, with the sums of all rows.
REQ-014 When not writing, ce_b1_o and we_b1_o SHALL be 0.
REQ-015 The status flags SHALL behave as follows:
- idle_o = state IDLE
- read_o = ce_b0_o
- write_o = ce_b1_o
- done_o = state DONE, a 1-cycle pulse
REQ-016 Total latency from start to done_o SHALL be N+3 cycles for N>0.

Reset
REQ-017 While reset is 1, all of the following SHALL hold immediately (asynchronously):
- state = IDLE, idle_o=1, all other outputs 0
- accumulators, counters and latched count = 0
REQ-018 Reset asserted mid-operation SHALL abort the run with no further BRAM access; a new start after deassertion SHALL begin from address 0.

Configuration
REQ-019 When ACC_SAT_EN is defined, each lane SHALL saturate at 2^ACC_WIDTH-1 and hold that value until the next start. When it is undefined, each lane SHALL wrap modulo 2^ACC_WIDTH.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Mode 0, N=4, rows 0x04030201 x4 -> BRAM1 writes at addr 0..3, lane0 = 1,2,3,4 and lane3 = 4,8,12,16, done_o at cycle 7.
- Mode 1, N=3, rows 0x01010101 -> one write to addr 0, every lane = 3, no other ce_b1_o pulses.
- run_count_i=0 -> done_o next cycle, ce_b0_o and ce_b1_o never 1.
- Overflow, ACC_WIDTH=8, lane=0xFF, N=2 -> 0xFE without ACC_SAT_EN, 0xFF with it.
- Reset asserted 2 cycles into READ with N=10 -> outputs 0 and idle_o=1 immediately; restart with N=2 -> addresses 0,1 and correct sums.
- start_run_i pulsed during READ -> ignored, exactly N writes.
